lbm_sweep_scheduler: RTL

- Sequences the lattice-Boltzmann timestep loop over the 18-RAM ping-pong distribution store (9 current banks, 9 next banks).
- Generates the shared word read and write addresses, write strobes, the bank select and the init strobe.
- Meters reads against the in-order results returned by the fused stream/collide datapath, then swaps banks once per step.
- Sits between the host run-control registers and the pipelined LBM controller datapath, replacing its free-running address logic.

---
 rtl/lbm_sweep_scheduler_pkg.sv | 22 ++
 rtl/lbm_sweep_scheduler_counter.sv | 31 +++
 rtl/lbm_sweep_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lbm_sweep_scheduler_pkg.sv
// Shared LBM sweep definitions: lattice geometry defaults and the scheduler state encoding.
// Geometry defaults are derived from the distribution RAM depth and lanes per word.
package lbm_sweep_scheduler_pkg;

    localparam int unsigned DEPTH          = 2500;
    localparam int unsigned RAMS_TO_ACCESS = 5;

    localparam int unsigned CELLS_DEF  = DEPTH;
    localparam int unsigned LANES_DEF  = RAMS_TO_ACCESS;
    localparam int unsigned WORDS_DEF  = CELLS_DEF / LANES_DEF;
    localparam int unsigned ADDR_W_DEF = $clog2(WORDS_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SWAP  = 3'd4,
        ST_PAUSE = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/lbm_sweep_scheduler_counter.sv
// Loadable, clearable up-counter with a terminal-count flag; used for the read and write sweeps.
// Clear has priority over load, load over increment.
module sweep_counter #(
    parameter int unsigned    W    = 10,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/lbm_sweep_scheduler.sv
// Timestep sequencer for the ping-pong LBM distribution store: init sweep, metered
// read/write-back sweeps, bank swap per step, pause at step boundaries.
module lbm_sweep_scheduler
    import lbm_sweep_scheduler_pkg::*;
#(
    parameter int unsigned CELLS   = CELLS_DEF,
    parameter int unsigned LANES   = LANES_DEF,
    parameter int unsigned WORDS   = CELLS / LANES,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [31:0]       steps,
    input  logic              dp_ready,
    input  logic              dp_wr_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              bank_sel,
    output logic              init_mode,
    output logic              busy,
    output logic              done,
    output logic [31:0]       steps_done,
    output logic              err
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);

    sweep_state_t state;
    logic [31:0]  steps_lat;

    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          rd_tc;
    logic          wr_tc;
    logic          rd_clear;
    logic          wr_clear;

    logic start_acc;
    logic in_sweep;
    logic wb_ok;
    logic stray_wb;
    logic last_step;
    logic init_last;

    sweep_counter #(
        .W    (CW),
        .TERM (LAST_C)
    ) u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (rd_clear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (rd_en),
        .count    (rd_cnt),
        .tc       (rd_tc)
    );

    // The write counter doubles as the init-sweep address generator.
    sweep_counter #(
        .W    (CW),
        .TERM (LAST_C)
    ) u_wr_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (wr_clear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wr_en),
        .count    (wr_cnt),
        .tc       (wr_tc)
    );

    always_comb begin
        start_acc = (state == ST_IDLE) && start;
        in_sweep  = (state == ST_RUN) || (state == ST_DRAIN);
        // A write-back is only legitimate while a read is still outstanding.
        wb_ok     = in_sweep && (wr_cnt != rd_cnt);
        stray_wb  = dp_wr_valid && !wb_ok;
        last_step = ({1'b0, steps_done} + 33'd1) == {1'b0, steps_lat};
        init_last = (state == ST_INIT) && wr_tc;

        rd_en = (state == ST_RUN) && dp_ready && (rd_cnt < WORDS_C)
                && ((rd_cnt - wr_cnt) < MAX_C);
        wr_en = (state == ST_INIT) || (dp_wr_valid && wb_ok);

        rd_addr   = rd_cnt[ADDR_W-1:0];
        wr_addr   = wr_cnt[ADDR_W-1:0];
        init_mode = (state == ST_INIT);
        busy      = (state != ST_IDLE);
        done      = (init_last && (steps_lat == '0))
                    || ((state == ST_SWAP) && last_step);

        rd_clear = start_acc || (state == ST_SWAP);
        wr_clear = start_acc || init_last || (state == ST_SWAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            steps_lat  <= '0;
            steps_done <= '0;
            bank_sel   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (stray_wb) begin
                err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        steps_lat  <= steps;
                        steps_done <= '0;
                        bank_sel   <= 1'b0;
                        err        <= 1'b0;
                        state      <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (wr_tc) begin
                        state <= (steps_lat == '0) ? ST_IDLE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_en && rd_tc) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_en && wr_tc) begin
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    bank_sel <= ~bank_sel;
                    if (steps_done != '1) begin
                        steps_done <= steps_done + 32'd1;
                    end
                    if (last_step) begin
                        state <= ST_IDLE;
                    end else if (en) begin
                        state <= ST_RUN;
                    end else begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
